pc_fetch_unit: RTL

//  Consumer of the branch unit's redirect outputs: owns the architectural PC, fetches

---
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/ack channel and the
// valid/ready channel towards decode.
//   master : the fetch unit (drives imem_req/imem_addr and if_valid/if_instr/if_pc)
//   slave  : memory + decode side (drives imem_ack/imem_rdata and if_ready)
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, if_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / instruction fetch unit.
// Owns the architectural PC, fetches over the imem req/ack channel and
// hands one buffered instruction at a time to decode over valid/ready.
// jmp/branch redirects from the branch unit restart fetch at the new PC,
// dropping any wrong-path instruction or in-flight fetch.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   jmp, branch         redirect requests (jmp has priority)
//   offset[15:0]        branch offset in words, sign-extended
//   target[25:0]        jump target in words
//   id_pc               PC of the instruction in decode
//   pc_high             (id_pc+4)[31:28], combinational
//   bus (master)        imem req/addr/ack/rdata, decode valid/ready/instr/pc
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp,
  input  logic        branch,
  input  logic [31:0] offset,
  input  logic [31:0] target,
  input  logic [31:0] id_pc,
  output logic [3:0]  pc_high,
  pc_fetch_unit_if.master bus
);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic        run_q, run_d;

  logic [31:0] seq_pc;
  logic [31:0] redir_pc;
  logic        redirect;
  logic        slot_busy;
  logic        req;
  logic        take;
  logic        unused_bits;

  always_comb begin
    seq_pc   = id_pc + 32'd4;
    pc_high  = seq_pc[31:28];
    redirect = jmp | branch;
    redir_pc = jmp ? {seq_pc[31:28], target[25:0], 2'b00}
                   : seq_pc + {{14{offset[15]}}, offset[15:0], 2'b00};
    unused_bits = ^{offset[31:16], target[31:26]};
  end

  // run_q keeps req low for the cycle following a reset edge.
  // In DISCARD the stale request must stay up until its ack arrives; in FETCH
  // a new request is only issued when the output slot can take the result.
  always_comb begin
    slot_busy = valid_q & ~bus.if_ready;
    req       = run_q & ((state_q == DISCARD) | ~slot_busy);
    take      = req & bus.imem_ack;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    run_d   = 1'b1;
    valid_d = valid_q & ~bus.if_ready;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          // Only an unanswered request needs its stale ack absorbed.
          if (req & ~bus.imem_ack) begin
            state_d = DISCARD;
            pend_d  = redir_pc;
          end else begin
            pc_d = redir_pc;
          end
        end else if (take) begin
          valid_d = 1'b1;
          instr_d = bus.imem_rdata;
          ifpc_d  = pc_q;
          pc_d    = pc_q + 32'(PC_STEP);
        end
      end
      DISCARD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pend_d  = redir_pc;
        end
        if (take) begin
          state_d = FETCH;
          pc_d    = pend_d;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    bus.imem_req  = req;
    bus.imem_addr = pc_q;
    bus.if_valid  = valid_q;
    bus.if_instr  = instr_q;
    bus.if_pc     = ifpc_q;
  end

endmodule
